cutthrough_filter_v2: RTL and testbench

Parametrised zero-latency AXI-Stream market-data filter; generalises the single-symbol cut-through dropper. The first beat of each packet is parsed for msg_type and symbol_id and checked against a runtime-writable symbol whitelist of NUM_SYMBOLS entries. Matching packets are forwarded beat-for-beat and non-matching packets are drained, with a held pulse header for the strategy path. Sits between the MAC/parser stream and the order-book/strategy pipeline.

---
 rtl/cutthrough_filter_v2.sv | 170 +++++++++++++++++
 tb/tb_cutthrough_filter_v2.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cutthrough_filter_v2.sv
// cutthrough_filter_v2: zero-latency AXI-Stream market-data filter.
// The first beat of each packet is parsed for msg_type/symbol_id and matched
// against a runtime-writable whitelist. Matching packets pass beat-for-beat,
// others are drained. The header of each forwarded packet is held on the pulse port.
// Build option: define CUTTHROUGH_STATS_EN to build the saturating statistics
// counters. Without it the stat_* ports are tied to zero.
module cutthrough_filter_v2 #(
  parameter int          WIDTH       = 64,
  parameter int          NUM_SYMBOLS = 8,
  parameter logic [7:0]  MSG_TYPE_0  = 8'h51,
  parameter logic [7:0]  MSG_TYPE_1  = 8'h54,
  parameter int          CNT_WIDTH   = 32,
  localparam int         AW          = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     slave_tdata,
  input  logic [WIDTH/8-1:0]   slave_byteEnable,
  input  logic                 slave_tvalid,
  input  logic                 slave_tlast,
  output logic                 slave_tready,
  output logic [WIDTH-1:0]     master_tdata,
  output logic [WIDTH/8-1:0]   master_byteEnable,
  output logic                 master_tvalid,
  output logic                 master_tlast,
  input  logic                 master_tready,
  input  logic                 cfg_wr_en,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [23:0]          cfg_symbol,
  input  logic                 cfg_entry_valid,
  input  logic                 cfg_bypass,
  output logic                 pulse_valid,
  input  logic                 pulse_ready,
  output logic [63:0]          pulse_header,
  output logic [CNT_WIDTH-1:0] stat_fwd_pkts,
  output logic [CNT_WIDTH-1:0] stat_drop_pkts,
  output logic [CNT_WIDTH-1:0] stat_pulse_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  state_t                       state_q;
  logic [NUM_SYMBOLS-1:0]       wl_vld_q;
  logic [NUM_SYMBOLS-1:0][23:0] wl_sym_q;
  logic [NUM_SYMBOLS-1:0]       hit;
  logic [7:0]                   msg_type;
  logic [23:0]                  symbol_id;
  logic                         type_ok, match, pass, hs, load;
  logic                         pulse_valid_q, pulse_valid_d;
  logic [63:0]                  pulse_header_q, pulse_header_d;

  assign msg_type  = slave_tdata[WIDTH-1 -: 8];
  assign symbol_id = slave_tdata[WIDTH-9 -: 24];

  // Whitelist lookup runs in parallel across all entries; only valid entries can hit.
  for (genvar i = 0; i < NUM_SYMBOLS; i++) begin : g_ent
    assign hit[i] = wl_vld_q[i] && (wl_sym_q[i] == symbol_id);
  end

  assign type_ok = (msg_type == MSG_TYPE_0) || (msg_type == MSG_TYPE_1);
  assign match   = cfg_bypass || (type_ok && |hit);

  // Mid-packet the decision is frozen in the state; only first beats consult match.
  assign pass = (state_q == S_IDLE) ? match : (state_q == S_FWD);

  assign master_tdata      = slave_tdata;
  assign master_byteEnable = slave_byteEnable;
  assign master_tlast      = slave_tlast;
  assign master_tvalid     = slave_tvalid && pass;
  assign slave_tready      = pass ? master_tready : 1'b1;

  assign hs   = slave_tvalid && slave_tready;
  assign load = hs && (state_q == S_IDLE) && match;

  // Whitelist table: writes become visible to the lookup on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wl_vld_q <= '0;
      wl_sym_q <= '0;
    end else if (cfg_wr_en) begin
      for (int i = 0; i < NUM_SYMBOLS; i++) begin
        if (cfg_addr == AW'(i)) begin
          wl_vld_q[i] <= cfg_entry_valid;
          wl_sym_q[i] <= cfg_symbol;
        end
      end
    end
  end

  // Packet framing FSM, advanced only on beat handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (hs) begin
      case (state_q)
        S_IDLE:  if (!slave_tlast) state_q <= match ? S_FWD : S_DROP;
        S_FWD,
        S_DROP:  if (slave_tlast) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pulse next-state: a new load always wins, otherwise pulse_ready consumes.
  always_comb begin
    pulse_valid_d  = pulse_valid_q;
    pulse_header_d = pulse_header_q;
    if (load) begin
      pulse_valid_d  = 1'b1;
      pulse_header_d = slave_tdata[WIDTH-1 -: 64];
    end else if (pulse_ready) begin
      pulse_valid_d  = 1'b0;
    end
  end

  // Pulse holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_valid_q  <= 1'b0;
      pulse_header_q <= '0;
    end else begin
      pulse_valid_q  <= pulse_valid_d;
      pulse_header_q <= pulse_header_d;
    end
  end

  assign pulse_valid  = pulse_valid_q;
  assign pulse_header = pulse_header_q;

`ifdef CUTTHROUGH_STATS_EN
  logic [CNT_WIDTH-1:0] fwd_q, fwd_d, drop_q, drop_d, ovr_q, ovr_d;
  logic                 pkt_end, ovr_ev;

  // A packet is counted once, on its last-beat handshake; pass reflects its decision.
  assign pkt_end = hs && slave_tlast;
  assign ovr_ev  = load && pulse_valid_q && !pulse_ready;

  // Saturating counter next-state.
  always_comb begin
    fwd_d  = fwd_q;
    drop_d = drop_q;
    ovr_d  = ovr_q;
    if (pkt_end && pass && (fwd_q != '1))   fwd_d  = fwd_q + CNT_WIDTH'(1);
    if (pkt_end && !pass && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
    if (ovr_ev && (ovr_q != '1))            ovr_d  = ovr_q + CNT_WIDTH'(1);
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q  <= '0;
      drop_q <= '0;
      ovr_q  <= '0;
    end else begin
      fwd_q  <= fwd_d;
      drop_q <= drop_d;
      ovr_q  <= ovr_d;
    end
  end

  assign stat_fwd_pkts      = fwd_q;
  assign stat_drop_pkts     = drop_q;
  assign stat_pulse_overrun = ovr_q;
`else
  assign stat_fwd_pkts      = '0;
  assign stat_drop_pkts     = '0;
  assign stat_pulse_overrun = '0;
`endif

endmodule

// File: tb/tb_cutthrough_filter_v2.sv
// tb_cutthrough_filter_v2: directed scenarios plus random traffic, every cycle
// compared against a packet-level reference model held in the bench.
module tb_cutthrough_filter_v2;
  localparam int W  = 128;
  localparam int NS = 5;
  localparam int CW = 4;
  localparam int AW = 3;
  localparam int BE = W / 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_tdata, m_tdata;
  logic [BE-1:0] s_be, m_be;
  logic          s_tvalid, s_tlast, s_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic          cfg_wr_en, cfg_entry_valid, cfg_bypass;
  logic [AW-1:0] cfg_addr;
  logic [23:0]   cfg_symbol;
  logic          pulse_valid, pulse_ready;
  logic [63:0]   pulse_header;
  logic [CW-1:0] stat_fwd, stat_drop, stat_ovr;

  cutthrough_filter_v2 #(.WIDTH(W), .NUM_SYMBOLS(NS), .MSG_TYPE_0(8'h51),
                         .MSG_TYPE_1(8'h54), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .slave_tdata(s_tdata), .slave_byteEnable(s_be), .slave_tvalid(s_tvalid),
    .slave_tlast(s_tlast), .slave_tready(s_tready),
    .master_tdata(m_tdata), .master_byteEnable(m_be), .master_tvalid(m_tvalid),
    .master_tlast(m_tlast), .master_tready(m_tready),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_symbol(cfg_symbol),
    .cfg_entry_valid(cfg_entry_valid), .cfg_bypass(cfg_bypass),
    .pulse_valid(pulse_valid), .pulse_ready(pulse_ready), .pulse_header(pulse_header),
    .stat_fwd_pkts(stat_fwd), .stat_drop_pkts(stat_drop), .stat_pulse_overrun(stat_ovr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: whitelist as plain arrays, packet progress as in-packet/keep flags,
  // counters as unbounded ints clipped at compare time.
  bit          m_v[NS];
  logic [23:0] m_s[NS];
  bit          m_mid, m_keep, m_pv;
  logic [63:0] m_ph;
  int          m_fwd, m_drop, m_ovr;
  bit          last_hs;

  function automatic bit m_match(input logic [W-1:0] d);
    logic [7:0]  mt = d[W-1 -: 8];
    logic [23:0] sy = d[W-9 -: 24];
    if (cfg_bypass) return 1'b1;
    if (mt != 8'h51 && mt != 8'h54) return 1'b0;
    for (int i = 0; i < NS; i++) if (m_v[i] && m_s[i] == sy) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] sx(input int c);
`ifdef CUTTHROUGH_STATS_EN
    return W'((c > SAT) ? SAT : c);
`else
    return '0;
`endif
  endfunction

  task automatic m_reset();
    m_mid = 0; m_keep = 0; m_pv = 0; m_ph = '0;
    m_fwd = 0; m_drop = 0; m_ovr = 0;
    for (int i = 0; i < NS; i++) begin m_v[i] = 0; m_s[i] = '0; end
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit p, hs, ld;
    logic [63:0] hdr;
    #4;
    p  = m_mid ? m_keep : m_match(s_tdata);
    hs = s_tvalid && (p ? m_tready : 1'b1);
    chk("m_tvalid", W'(m_tvalid), W'(s_tvalid && p));
    chk("s_tready", W'(s_tready), W'(p ? m_tready : 1'b1));
    chk("m_tdata",  m_tdata, s_tdata);
    chk("m_tlast",  W'(m_tlast), W'(s_tlast));
    chk("m_be",     W'(m_be), W'(s_be));
    chk("p_valid",  W'(pulse_valid), W'(m_pv));
    chk("p_header", W'(pulse_header), W'(m_ph));
    chk("st_fwd",   W'(stat_fwd), sx(m_fwd));
    chk("st_drop",  W'(stat_drop), sx(m_drop));
    chk("st_ovr",   W'(stat_ovr), sx(m_ovr));
    last_hs = hs;
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      ld  = hs && !m_mid && p;
      hdr = s_tdata[W-1 -: 64];
      if (hs) begin
        if (!m_mid) begin
          if (s_tlast) begin if (p) m_fwd++; else m_drop++; end
          else begin m_mid = 1; m_keep = p; end
        end else if (s_tlast) begin
          if (m_keep) m_fwd++; else m_drop++;
          m_mid = 0;
        end
      end
      if (ld && m_pv && !pulse_ready) m_ovr++;
      if (ld) begin m_pv = 1; m_ph = hdr; end
      else if (pulse_ready) m_pv = 0;
      if (cfg_wr_en && int'(cfg_addr) < NS) begin
        m_v[cfg_addr] = cfg_entry_valid;
        m_s[cfg_addr] = cfg_symbol;
      end
    end
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input bit last);
    s_tdata = d; s_tlast = last; s_be = BE'($urandom); s_tvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_hs) begin s_tvalid = 1'b0; return; end
    end
    chk("hs_timeout", W'(0), W'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] sy, input bit v);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_symbol = sy; cfg_entry_valid = v;
    step();
    cfg_wr_en = 1'b0;
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] mt, input logic [23:0] sy);
    return {mt, sy, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [23:0] pool[6] = '{24'h415041, 24'h474F4F, 24'h4D5346, 24'h414D5A, 24'h000000, 24'hFFFFFF};

  function automatic logic [W-1:0] rhdr();
    logic [7:0] mt;
    case ($urandom_range(0, 3))
      0: mt = 8'h51;
      1: mt = 8'h54;
      2: mt = 8'h41;
      default: mt = 8'($urandom);
    endcase
    return mk(mt, pool[$urandom_range(0, 5)]);
  endfunction

  initial begin
    logic [W-1:0] h, h2, b[4];
    int bi, len;
    rst = 1; s_tdata = '0; s_be = '0; s_tvalid = 0; s_tlast = 0; m_tready = 1;
    cfg_wr_en = 0; cfg_addr = '0; cfg_symbol = '0; cfg_entry_valid = 0; cfg_bypass = 0;
    pulse_ready = 0;
    m_reset();
    #6;
    step();
    rst = 0;
    step();

    // Matching 3-beat packet is forwarded and its header lands on the pulse port.
    wr(3'd0, 24'h415041, 1'b1);
    h = mk(8'h51, 24'h415041);
    beat(h, 1'b0);
    chk("t1_pv", W'(pulse_valid), W'(1));
    chk("t1_ph", W'(pulse_header), W'(h[W-1 -: 64]));
    beat(rnd(), 1'b0);
    beat(rnd(), 1'b1);
    chk("t1_fwd", W'(stat_fwd), sx(1));
    pulse_ready = 1; step(); pulse_ready = 0;

    // Wrong symbol, then wrong msg_type: both drained.
    beat(mk(8'h51, 24'h474F4F), 1'b0); beat(rnd(), 1'b0); beat(rnd(), 1'b1);
    beat(mk(8'h41, 24'h415041), 1'b0); beat(rnd(), 1'b0); beat(rnd(), 1'b1);
    chk("t2_drop", W'(stat_drop), sx(2));
    chk("t2_pv", W'(pulse_valid), W'(0));

    // Back-pressure toggling on a 4-beat matching packet.
    b[0] = mk(8'h54, 24'h415041); b[1] = rnd(); b[2] = rnd(); b[3] = rnd();
    bi = 0;
    for (int k = 0; k < 16 && bi < 4; k++) begin
      s_tdata = b[bi]; s_tlast = (bi == 3); s_be = BE'($urandom); s_tvalid = 1'b1;
      m_tready = (k % 2 == 0);
      step();
      if (last_hs) bi++;
    end
    s_tvalid = 0; m_tready = 1;
    chk("t3_beats", W'(bi), W'(4));
    chk("t3_fwd", W'(stat_fwd), sx(2));
    pulse_ready = 1; step(); pulse_ready = 0;

    // Pulse overrun, then same-cycle consume-and-load without overrun.
    h = mk(8'h51, 24'h415041); h2 = mk(8'h54, 24'h415041);
    beat(h, 1'b1); beat(h2, 1'b1);
    chk("t4_ph", W'(pulse_header), W'(h2[W-1 -: 64]));
    chk("t4_ovr", W'(stat_ovr), sx(1));
    pulse_ready = 1; step(); pulse_ready = 0;
    beat(h, 1'b1);
    pulse_ready = 1; beat(h2, 1'b1); pulse_ready = 0;
    chk("t4_ovr2", W'(stat_ovr), sx(1));
    chk("t4_pv2", W'(pulse_valid), W'(1));
    pulse_ready = 1; step(); pulse_ready = 0;

    // Entry cleared mid-packet: in-flight packet completes, next one drops, bypass forwards.
    h = mk(8'h51, 24'h415041);
    beat(h, 1'b0);
    cfg_wr_en = 1; cfg_addr = 3'd0; cfg_symbol = 24'h415041; cfg_entry_valid = 0;
    beat(rnd(), 1'b0);
    cfg_wr_en = 0;
    beat(rnd(), 1'b1);
    chk("t5_fwd", W'(stat_fwd), sx(7));
    beat(h, 1'b1);
    chk("t5_drop", W'(stat_drop), sx(3));
    cfg_bypass = 1; beat(h, 1'b1); cfg_bypass = 0;
    chk("t5_byp", W'(stat_fwd), sx(8));

    // Out-of-range address writes are ignored.
    wr(3'd6, 24'h415041, 1'b1);
    beat(h, 1'b1);
    chk("t6_oor", W'(stat_drop), sx(4));

    // Reset during beat 1; beat 2 is then parsed as a first beat.
    wr(3'd0, 24'h415041, 1'b1);
    beat(h, 1'b0);
    s_tdata = rnd(); s_tlast = 0; s_tvalid = 1; rst = 1;
    step();
    rst = 0; s_tvalid = 0;
    chk("t7_fwd", W'(stat_fwd), W'(0));
    chk("t7_pv", W'(pulse_valid), W'(0));
    beat(h, 1'b1);
    chk("t7_drop", W'(stat_drop), sx(1));

    // Random traffic, config churn, back-pressure and occasional reset.
    bi = 0; len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (s_tvalid && last_hs) begin bi++; s_tvalid = 0; end
      if (bi >= len) begin len = $urandom_range(1, 4); bi = 0; end
      if (!s_tvalid && $urandom_range(0, 3) != 0) begin
        s_tdata = (bi == 0) ? rhdr() : rnd();
        s_tlast = (bi == len - 1); s_be = BE'($urandom); s_tvalid = 1;
      end
      m_tready        = ($urandom_range(0, 3) != 0);
      pulse_ready     = ($urandom_range(0, 2) == 0);
      cfg_wr_en       = ($urandom_range(0, 9) == 0);
      cfg_addr        = AW'($urandom_range(0, 7));
      cfg_symbol      = pool[$urandom_range(0, 3)];
      cfg_entry_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) cfg_bypass = ~cfg_bypass;
      rst             = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; s_tvalid = 0; cfg_wr_en = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
